// File: rtl/foc_stage_if.sv
// Start/done handshake bundle between the loop sequencer and the four FOC datapath stages.
interface foc_stage_if;
  logic adc_start;
  logic xform_start;
  logic pi_start;
  logic pwm_start;
  logic adc_done;
  logic xform_done;
  logic pi_done;
  logic pwm_done;

  modport master (
    output adc_start, xform_start, pi_start, pwm_start,
    input  adc_done, xform_done, pi_done, pwm_done
  );

  modport slave (
    input  adc_start, xform_start, pi_start, pwm_start,
    output adc_done, xform_done, pi_done, pwm_done
  );
endinterface

// File: rtl/foc_loop_sequencer.sv
// Runs one ADC -> Clarke/Park -> PI -> PWM iteration per control tick, with per-stage
// watchdog, saturating tick-overrun count and last-iteration latency measurement.
module foc_loop_sequencer #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned LAT_W   = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             tick,
  input  logic             clear_fault,
  foc_stage_if.master      stg,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       fault_stage,
  output logic [CNT_W-1:0] overrun_cnt,
  output logic [LAT_W-1:0] last_latency
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StAdc, StXform, StPi, StPwm, StFault} state_e;

  state_e             state_q, state_d, next_stage;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [LAT_W-1:0]   lat_q, lat_d, last_lat_q, last_lat_d;
  logic [CNT_W-1:0]   ovr_q, ovr_d;
  logic [3:0]         start_q, start_d;
  logic               busy_q, busy_d, fault_q, fault_d;
  logic [1:0]         fault_stage_q, fault_stage_d, stage_idx;
  logic               in_stage, stage_done, timed_out, entering;

  always_comb begin
    state_d       = state_q;
    in_stage      = 1'b0;
    stage_done    = 1'b0;
    stage_idx     = 2'd0;
    next_stage    = StIdle;
    unique case (state_q)
      StAdc:   begin in_stage = 1'b1; stage_done = stg.adc_done;   stage_idx = 2'd0;
                     next_stage = StXform; end
      StXform: begin in_stage = 1'b1; stage_done = stg.xform_done; stage_idx = 2'd1;
                     next_stage = StPi; end
      StPi:    begin in_stage = 1'b1; stage_done = stg.pi_done;    stage_idx = 2'd2;
                     next_stage = StPwm; end
      StPwm:   begin in_stage = 1'b1; stage_done = stg.pwm_done;   stage_idx = 2'd3;
                     next_stage = StIdle; end
      default: ;
    endcase

    // Done beats the watchdog when both land in the same cycle.
    timed_out = in_stage && !stage_done && (timer_q == TMR_LAST);

    if (state_q == StIdle) begin
      if (tick && en) state_d = StAdc;
    end else if (state_q == StFault) begin
      if (clear_fault) state_d = StIdle;
    end else if (stage_done) begin
      state_d = next_stage;
    end else if (timed_out) begin
      state_d = StFault;
    end

    entering = (state_d != state_q);
    timer_d  = (in_stage && !entering) ? timer_q + 1'b1 : '0;

    // The ADC entry cycle is the first busy cycle of the iteration.
    if (state_q == StIdle && state_d == StAdc) lat_d = LAT_W'(1);
    else if (in_stage && lat_q != '1)          lat_d = lat_q + 1'b1;
    else                                       lat_d = lat_q;

    last_lat_d = (state_q == StPwm && state_d == StIdle) ? lat_q : last_lat_q;

    start_d = '0;
    if (entering) begin
      case (state_d)
        StAdc:   start_d[0] = 1'b1;
        StXform: start_d[1] = 1'b1;
        StPi:    start_d[2] = 1'b1;
        StPwm:   start_d[3] = 1'b1;
        default: ;
      endcase
    end

    busy_d        = (state_d == StAdc) || (state_d == StXform) ||
                    (state_d == StPi)  || (state_d == StPwm);
    fault_d       = (state_d == StFault);
    fault_stage_d = timed_out ? stage_idx : fault_stage_q;
    ovr_d         = (tick && busy_q && ovr_q != '1) ? ovr_q + 1'b1 : ovr_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      lat_q         <= '0;
      last_lat_q    <= '0;
      ovr_q         <= '0;
      start_q       <= '0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_stage_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      lat_q         <= lat_d;
      last_lat_q    <= last_lat_d;
      ovr_q         <= ovr_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign stg.adc_start   = start_q[0];
  assign stg.xform_start = start_q[1];
  assign stg.pi_start    = start_q[2];
  assign stg.pwm_start   = start_q[3];
  assign busy            = busy_q;
  assign fault           = fault_q;
  assign fault_stage     = fault_stage_q;
  assign overrun_cnt     = ovr_q;
  assign last_latency    = last_lat_q;

endmodule

// File: tb/tb_foc_loop_sequencer.sv
// Self-checking bench for foc_loop_sequencer: directed scenarios plus randomized iterations
// checked against start times and latency computed from per-stage done delays.
module tb_foc_loop_sequencer;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 2;
  localparam int unsigned LW = 12;

  logic          clk = 1'b0;
  logic          nrst, en, tick, clear_fault;
  logic          busy, fault;
  logic [1:0]    fault_stage;
  logic [CW-1:0] overrun_cnt;
  logic [LW-1:0] last_latency;

  foc_stage_if stg ();

  foc_loop_sequencer #(.TIMEOUT(TO), .CNT_W(CW), .LAT_W(LW)) dut (
    .clk(clk), .nrst(nrst), .en(en), .tick(tick), .clear_fault(clear_fault), .stg(stg),
    .busy(busy), .fault(fault), .fault_stage(fault_stage), .overrun_cnt(overrun_cnt),
    .last_latency(last_latency)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int dly[4];
  int cnt[4];
  bit active[4];
  int st_time[4];
  int st_cnt[4];
  bit spur = 1'b0;

  function automatic logic [3:0] starts();
    return {stg.pwm_start, stg.pi_start, stg.xform_start, stg.adc_start};
  endfunction

  task automatic set_done(input logic [3:0] d);
    stg.adc_done   = d[0];
    stg.xform_done = d[1];
    stg.pi_done    = d[2];
    stg.pwm_done   = d[3];
  endtask

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
  endtask

  // One clock: sample just after the edge, then play the datapath stages' done responses.
  task automatic cycle();
    logic [3:0] s, d;
    @(posedge clk);
    #1;
    cyc++;
    tick = 1'b0;
    clear_fault = 1'b0;
    d = '0;
    s = starts();
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        active[i] = 1'b1; cnt[i] = 0; st_time[i] = cyc; st_cnt[i]++;
      end
      if (active[i]) begin
        if (cnt[i] == dly[i]) begin d[i] = 1'b1; active[i] = 1'b0; end
        else cnt[i]++;
      end
    end
    if (fault) for (int i = 0; i < 4; i++) active[i] = 1'b0;
    if (spur)
      for (int i = 0; i < 4; i++)
        if (!active[i] && !d[i] && !s[i] && ($urandom % 3 == 0)) d[i] = 1'b1;
    set_done(d);
  endtask

  task automatic launch();
    tick = 1'b1;
    cycle();
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy === 1'b1 && n < bound) begin cycle(); n++; end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL wait_idle busy=%0b want=0", busy); end
  endtask

  task automatic do_reset();
    nrst = 1'b0; en = 1'b0; tick = 1'b0; clear_fault = 1'b0; set_done(4'b0);
    for (int i = 0; i < 4; i++) begin active[i] = 1'b0; st_cnt[i] = 0; end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (starts() !== 4'b0) begin bad++; $display("FAIL rst_starts got=%b want=0000", starts()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
    if (fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%0b want=0", fault); end
    if (fault_stage !== 2'd0) begin bad++; $display("FAIL rst_fstage got=%0d want=0", fault_stage); end
    if (overrun_cnt !== '0) begin bad++; $display("FAIL rst_ovr got=%0d want=0", overrun_cnt); end
    if (last_latency !== '0) begin bad++; $display("FAIL rst_lat got=%0d want=0", last_latency); end
  endtask

  task automatic test_min_iteration();
    en = 1'b1;
    set_dly(0, 0, 0, 0);
    launch();
    for (int k = 0; k < 4; k++) begin
      total += 2;
      if (starts() !== (4'b1 << k)) begin
        bad++; $display("FAIL min_start%0d got=%b want=%b", k, starts(), 4'b1 << k);
      end
      if (busy !== 1'b1) begin bad++; $display("FAIL min_busy%0d got=%0b want=1", k, busy); end
      cycle();
    end
    total += 3;
    if (busy !== 1'b0) begin bad++; $display("FAIL min_idle got=%0b want=0", busy); end
    if (starts() !== 4'b0) begin bad++; $display("FAIL min_nostart got=%b want=0000", starts()); end
    if (last_latency !== 12'd4) begin bad++; $display("FAIL min_lat got=%0d want=4", last_latency); end
  endtask

  task automatic test_adc_delay();
    set_dly(10, 0, 0, 0);
    launch();
    wait_idle(40);
    total += 2;
    if (st_time[1] - st_time[0] !== 11) begin
      bad++; $display("FAIL adcdly_gap got=%0d want=11", st_time[1] - st_time[0]);
    end
    if (last_latency !== 12'd14) begin bad++; $display("FAIL adcdly_lat got=%0d want=14", last_latency); end
  endtask

  task automatic test_timeout();
    int p, n0;
    do_reset();
    en = 1'b1;
    set_dly(0, 0, 0, 0);
    launch();
    wait_idle(10);
    set_dly(0, 0, 1000, 0);
    launch();
    cycle(); cycle();
    p = cyc;
    total++;
    if (stg.pi_start !== 1'b1) begin bad++; $display("FAIL to_pistart got=%0b want=1", stg.pi_start); end
    repeat (TO - 1) cycle();
    total += 2;
    if (fault !== 1'b0) begin bad++; $display("FAIL to_early got=%0b want=0 at +%0d", fault, cyc - p); end
    if (busy !== 1'b1) begin bad++; $display("FAIL to_busy got=%0b want=1", busy); end
    cycle();
    total += 3;
    if (fault !== 1'b1) begin bad++; $display("FAIL to_fault got=%0b want=1 at +%0d", fault, cyc - p); end
    if (fault_stage !== 2'd2) begin bad++; $display("FAIL to_fstage got=%0d want=2", fault_stage); end
    if (busy !== 1'b0) begin bad++; $display("FAIL to_busy0 got=%0b want=0", busy); end
    n0 = st_cnt[0];
    repeat (3) begin tick = 1'b1; cycle(); end
    total += 4;
    if (st_cnt[0] !== n0) begin bad++; $display("FAIL to_noadc got=%0d want=%0d", st_cnt[0], n0); end
    if (overrun_cnt !== '0) begin bad++; $display("FAIL to_ovr got=%0d want=0", overrun_cnt); end
    if (fault !== 1'b1) begin bad++; $display("FAIL to_hold got=%0b want=1", fault); end
    if (last_latency !== 12'd4) begin bad++; $display("FAIL to_lat got=%0d want=4", last_latency); end
    clear_fault = 1'b1;
    cycle();
    total += 2;
    if (fault !== 1'b0) begin bad++; $display("FAIL to_clear got=%0b want=0", fault); end
    if (fault_stage !== 2'd2) begin bad++; $display("FAIL to_fshold got=%0d want=2", fault_stage); end
    set_dly(0, 0, 0, 0);
    launch();
    total++;
    if (stg.adc_start !== 1'b1) begin bad++; $display("FAIL to_relaunch got=%0b want=1", stg.adc_start); end
    wait_idle(10);
  endtask

  task automatic test_boundary();
    set_dly(0, 0, TO - 1, 0);
    launch();
    cycle(); cycle();
    repeat (TO) cycle();
    total += 2;
    if (stg.pwm_start !== 1'b1) begin bad++; $display("FAIL bnd_pwm got=%0b want=1", stg.pwm_start); end
    if (fault !== 1'b0) begin bad++; $display("FAIL bnd_fault got=%0b want=0", fault); end
    wait_idle(10);
  endtask

  task automatic test_overrun();
    int n0;
    do_reset();
    en = 1'b1;
    set_dly(0, 0, 0, 10);
    launch();
    repeat (3) cycle();
    total++;
    if (stg.pwm_start !== 1'b1) begin bad++; $display("FAIL ovr_pwm got=%0b want=1", stg.pwm_start); end
    n0 = st_cnt[0];
    repeat (5) begin tick = 1'b1; cycle(); end
    total += 2;
    if (overrun_cnt !== 2'd3) begin bad++; $display("FAIL ovr_sat got=%0d want=3", overrun_cnt); end
    if (st_cnt[0] !== n0) begin bad++; $display("FAIL ovr_noadc got=%0d want=%0d", st_cnt[0], n0); end
    wait_idle(20);
    total++;
    if (last_latency !== 12'd14) begin bad++; $display("FAIL ovr_lat got=%0d want=14", last_latency); end
    set_dly(0, 0, 0, 0);
    launch();
    total++;
    if (stg.adc_start !== 1'b1) begin bad++; $display("FAIL ovr_relaunch got=%0b want=1", stg.adc_start); end
    wait_idle(10);
  endtask

  task automatic test_en_drop();
    int n0;
    set_dly(0, 5, 0, 0);
    launch();
    cycle();
    en = 1'b0;
    wait_idle(20);
    total++;
    if (last_latency !== 12'd9) begin bad++; $display("FAIL en_lat got=%0d want=9", last_latency); end
    n0 = st_cnt[0];
    tick = 1'b1;
    cycle();
    repeat (3) cycle();
    total += 2;
    if (st_cnt[0] !== n0) begin bad++; $display("FAIL en_noadc got=%0d want=%0d", st_cnt[0], n0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL en_busy got=%0b want=0", busy); end
    en = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] oc;
    set_dly(0, 0, 0, 0);
    launch();
    repeat (4) cycle();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b want=0", busy); end
    oc = overrun_cnt;
    tick = 1'b1;
    cycle();
    total += 2;
    if (stg.adc_start !== 1'b1) begin bad++; $display("FAIL b2b_launch got=%0b want=1", stg.adc_start); end
    if (overrun_cnt !== oc) begin bad++; $display("FAIL b2b_ovr got=%0d want=%0d", overrun_cnt, oc); end
    wait_idle(10);
  endtask

  task automatic test_reset_mid();
    set_dly(0, 0, 1000, 0);
    tick = 1'b1; cycle();
    tick = 1'b1; cycle();
    cycle();
    total++;
    if (stg.pi_start !== 1'b1) begin bad++; $display("FAIL rm_pi got=%0b want=1", stg.pi_start); end
    nrst = 1'b0;
    #1;
    total += 6;
    if (starts() !== 4'b0) begin bad++; $display("FAIL rm_starts got=%b want=0000", starts()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%0b want=0", busy); end
    if (fault !== 1'b0) begin bad++; $display("FAIL rm_fault got=%0b want=0", fault); end
    if (fault_stage !== 2'd0) begin bad++; $display("FAIL rm_fstage got=%0d want=0", fault_stage); end
    if (overrun_cnt !== '0) begin bad++; $display("FAIL rm_ovr got=%0d want=0", overrun_cnt); end
    if (last_latency !== '0) begin bad++; $display("FAIL rm_lat got=%0d want=0", last_latency); end
    for (int i = 0; i < 4; i++) active[i] = 1'b0;
    set_done(4'b0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  // Expected start cycles follow from the done delays alone: each stage starts the cycle
  // after its predecessor's done, and the loop is busy from ADC start until PWM done.
  task automatic test_random();
    int es[4];
    int idle, ov, c;
    logic [3:0] exp_s;
    do_reset();
    en = 1'b1;
    spur = 1'b1;
    ov = 0;
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < 4; i++)
        dly[i] = ($urandom % 4 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, TO - 1));
      repeat ($urandom_range(0, 3)) cycle();
      c = cyc;
      es[0] = c + 1;
      for (int i = 1; i < 4; i++) es[i] = es[i-1] + dly[i-1] + 1;
      idle = es[3] + dly[3] + 1;
      launch();
      while (cyc < idle) begin
        exp_s = '0;
        for (int i = 0; i < 4; i++) if (cyc == es[i]) exp_s[i] = 1'b1;
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL rnd_busy it=%0d got=%0b want=1", it, busy); end
        if (starts() !== exp_s) begin
          bad++; $display("FAIL rnd_starts it=%0d got=%b want=%b", it, starts(), exp_s);
        end
        if ($urandom % 4 == 0) begin tick = 1'b1; ov++; end
        cycle();
      end
      total += 4;
      if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle it=%0d got=%0b want=0", it, busy); end
      if (fault !== 1'b0) begin bad++; $display("FAIL rnd_fault it=%0d got=%0b want=0", it, fault); end
      if (last_latency !== LW'(idle - es[0])) begin
        bad++; $display("FAIL rnd_lat it=%0d got=%0d want=%0d", it, last_latency, idle - es[0]);
      end
      if (overrun_cnt !== CW'((ov > 3) ? 3 : ov)) begin
        bad++; $display("FAIL rnd_ovr it=%0d got=%0d want=%0d", it, overrun_cnt, (ov > 3) ? 3 : ov);
      end
    end
    spur = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_min_iteration();
    test_adc_delay();
    test_timeout();
    test_boundary();
    test_overrun();
    test_en_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
